// File: rtl/avs_s0_pkg.sv
// avs_s0_pkg
// Shared definitions for the avs_s0 register responder:
//   - word addresses of the four registers
//   - bit positions inside the STATUS word
//   - handshake FSM state encoding
package avs_s0_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_DATA   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_CYCLES = 2'd3;

  localparam int STAT_COUNT_LSB = 0;
  localparam int STAT_COUNT_MSB = 15;
  localparam int STAT_EMPTY     = 16;
  localparam int STAT_FULL      = 17;
  localparam int STAT_OVERFLOW  = 18;
  localparam int STAT_UNDERFLOW = 19;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/avs_s0_fifo.sv
// avs_s0_fifo
// Synchronous FIFO behind the DATA window of the responder.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, wdata     write request and data (ignored when full)
//   pop             remove head entry (ignored when empty)
//   head            current head entry, combinational so the parent can
//                   latch it on the same edge that pops it
//   count           number of stored entries (0..DEPTH)
//   full, empty     occupancy flags
module avs_s0_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign count   = count_reg;
  assign head    = mem[rd_ptr_reg];

  // Storage carries no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/avs_s0_reg_responder.sv
// avs_s0_reg_responder
// Avalon-MM slave terminating the avalon_export_0_avs_s0 export. Word
// addressed, 32-bit, with WAIT_STATES extra cycles between request capture
// and acknowledge. Registers: 0 CTRL scratch, 1 DATA, 2 STATUS, 3 CYCLES.
// Build option: define AVS_FIFO_EN to back address 1 with an avs_s0_fifo
// (push on write, pop on read) and report its state in STATUS; without it
// address 1 is a plain register and STATUS reads zero.
// Ports:
//   clk_clk, reset_reset   clock, asynchronous active-high reset
//   avs_s0_address         word address
//   avs_s0_read/_write     commands; write wins when both are high
//   avs_s0_writedata       write data
//   avs_s0_readdata        registered read data, valid in the ACK cycle
//   avs_s0_waitrequest     low only during the ACK cycle
module avs_s0_reg_responder
  import avs_s0_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic [1:0]  avs_s0_address,
  input  logic        avs_s0_read,
  input  logic        avs_s0_write,
  input  logic [31:0] avs_s0_writedata,
  output logic [31:0] avs_s0_readdata,
  output logic        avs_s0_waitrequest
);

  localparam bit         NO_WAIT   = (WAIT_STATES == 0);
  localparam logic [3:0] WAIT_LAST = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

  state_t      state_reg;
  logic [3:0]  wait_cnt_reg;
  logic        waitrequest_reg;
  logic [31:0] readdata_reg;
  logic [31:0] ctrl_reg;
  logic [31:0] cycles_reg;
  logic [31:0] cycles_next;
  logic [31:0] rd_mux;
  logic [31:0] status_word;
  logic [31:0] data_word;
  logic        req;
  logic        capture;
  logic        do_write;
  logic        do_read;

  assign req = avs_s0_read | avs_s0_write;

  // The capture edge is the one that moves the FSM into ACK; every side
  // effect is keyed off it so a transfer acts exactly once.
  assign capture  = (state_reg == IDLE && req && NO_WAIT) ||
                    (state_reg == WAIT && wait_cnt_reg == 4'd0);
  assign do_write = capture & avs_s0_write;
  assign do_read  = capture & avs_s0_read & ~avs_s0_write;

  assign avs_s0_waitrequest = waitrequest_reg;
  assign avs_s0_readdata    = readdata_reg;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_reg       <= IDLE;
      wait_cnt_reg    <= 4'd0;
      waitrequest_reg <= 1'b1;
      readdata_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req) begin
            if (NO_WAIT) begin
              state_reg       <= ACK;
              waitrequest_reg <= 1'b0;
            end else begin
              state_reg    <= WAIT;
              wait_cnt_reg <= WAIT_LAST;
            end
          end
        end
        WAIT: begin
          if (wait_cnt_reg == 4'd0) begin
            state_reg       <= ACK;
            waitrequest_reg <= 1'b0;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 4'd1;
          end
        end
        ACK: begin
          state_reg       <= IDLE;
          waitrequest_reg <= 1'b1;
        end
        default: begin
          state_reg       <= IDLE;
          waitrequest_reg <= 1'b1;
        end
      endcase
      if (do_read) begin
        readdata_reg <= rd_mux;
      end
    end
  end

  // A load on the capture edge overrides the increment.
  assign cycles_next = (do_write && avs_s0_address == ADDR_CYCLES) ?
                       avs_s0_writedata : cycles_reg + 32'd1;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      ctrl_reg   <= '0;
      cycles_reg <= '0;
    end else begin
      cycles_reg <= cycles_next;
      if (do_write && avs_s0_address == ADDR_CTRL) begin
        ctrl_reg <= avs_s0_writedata;
      end
    end
  end

  // CYCLES reports the value the counter takes on the capture edge, so the
  // readdata seen in ACK matches the counter during that same cycle.
  always_comb begin
    rd_mux = '0;
    case (avs_s0_address)
      ADDR_CTRL:   rd_mux = ctrl_reg;
      ADDR_DATA:   rd_mux = data_word;
      ADDR_STATUS: rd_mux = status_word;
      ADDR_CYCLES: rd_mux = cycles_next;
      default:     rd_mux = '0;
    endcase
  end

`ifdef AVS_FIFO_EN
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [31:0]      fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             ovf_reg;
  logic             udf_reg;
  logic             status_wr;

  assign fifo_push = do_write && avs_s0_address == ADDR_DATA;
  assign fifo_pop  = do_read && avs_s0_address == ADDR_DATA;
  assign status_wr = do_write && avs_s0_address == ADDR_STATUS;

  avs_s0_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_avs_s0_fifo (
    .clk   (clk_clk),
    .rst   (reset_reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (avs_s0_writedata),
    .head  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Popping an empty FIFO returns zero rather than stale storage.
  assign data_word = fifo_empty ? 32'd0 : fifo_head;

  always_comb begin
    status_word = '0;
    status_word[STAT_COUNT_MSB:STAT_COUNT_LSB] = 16'(fifo_count);
    status_word[STAT_EMPTY]     = fifo_empty;
    status_word[STAT_FULL]      = fifo_full;
    status_word[STAT_OVERFLOW]  = ovf_reg;
    status_word[STAT_UNDERFLOW] = udf_reg;
  end

  // Sticky error flags, cleared by writing 1 to their STATUS bit.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      ovf_reg <= 1'b0;
      udf_reg <= 1'b0;
    end else begin
      if (fifo_push && fifo_full) begin
        ovf_reg <= 1'b1;
      end else if (status_wr && avs_s0_writedata[STAT_OVERFLOW]) begin
        ovf_reg <= 1'b0;
      end
      if (fifo_pop && fifo_empty) begin
        udf_reg <= 1'b1;
      end else if (status_wr && avs_s0_writedata[STAT_UNDERFLOW]) begin
        udf_reg <= 1'b0;
      end
    end
  end
`else
  logic [31:0] data_reg;

  // FIFO_DEPTH has no meaning without the FIFO; sink it so it stays referenced.
  logic unused_fifo_depth;
  assign unused_fifo_depth = ^(32'(FIFO_DEPTH));

  assign data_word   = data_reg;
  assign status_word = '0;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      data_reg <= '0;
    end else if (do_write && avs_s0_address == ADDR_DATA) begin
      data_reg <= avs_s0_writedata;
    end
  end
`endif

endmodule
